// File: rtl/soc_io_pkg.sv
// Shared SoC IO map and the UART receive FSM state encoding.
// Every IO peripheral and the bus decoder import this package.
package soc_io_pkg;

    localparam logic [31:0] UART_TX_ADDR        = 32'h4000_0000;
    localparam logic [31:0] UART_TX_STATUS_ADDR = 32'h4000_0004;
    localparam logic [31:0] UART_RX_DATA_ADDR   = 32'h4000_0008;
    localparam logic [31:0] UART_RX_STATUS_ADDR = 32'h4000_000C;
    localparam logic [31:0] MEPC_ADDR           = 32'h4000_0010;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

    // Receive status register layout:
    // [8:4] count, [3] full, [2] framing error, [1] overrun, [0] not empty.
    function automatic logic [31:0] rx_status_word(input logic [4:0] count,
                                                   input logic       full,
                                                   input logic       framing_error,
                                                   input logic       overrun,
                                                   input logic       not_empty);
        return {23'b0, count, full, framing_error, overrun, not_empty};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separately maintained occupancy count.
// A pop on a full FIFO frees the slot, so a same-cycle push is accepted.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clock,
    input  logic             resetActiveLow,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_port.sv
// UART 8N1 receiver with a receive FIFO behind two memory-mapped registers.
// Reading the data register pops; reading the status register clears error flags.
module uart_rx_port
    import soc_io_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 108,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] DATA_ADDR    = UART_RX_DATA_ADDR,
    parameter logic [31:0] STATUS_ADDR  = UART_RX_STATUS_ADDR
) (
    input  logic        clock,
    input  logic        resetActiveLow,
    input  logic        uartReceive,
    input  logic        ioReadValid,
    input  logic [31:0] ioReadAddress,
    output logic [31:0] ioReadData,
    output logic        rxInterrupt
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             sync1_q, sync2_q;
    logic             overrun_q, overrun_d;
    logic             framing_q, framing_d;
    logic             rx_push;
    logic             frame_err;
    logic             rx_s;

    logic             rd_data;
    logic             rd_status;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [4:0]       count5;

    // Idle-high synchroniser so reset does not look like a start bit.
    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uartReceive;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_push   = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_BIT) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        rx_push = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            overrun_q <= 1'b0;
            framing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            overrun_q <= overrun_d;
            framing_q <= framing_d;
        end
    end

    assign rd_data   = ioReadValid && (ioReadAddress == DATA_ADDR);
    assign rd_status = ioReadValid && (ioReadAddress == STATUS_ADDR);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock          (clock),
        .resetActiveLow (resetActiveLow),
        .push_i         (rx_push),
        .pop_i          (rd_data),
        .wdata_i        (shift_q),
        .rdata_o        (fifo_rdata),
        .full_o         (fifo_full),
        .empty_o        (fifo_empty),
        .count_o        (fifo_count)
    );

    // Clear-on-read comes first so an error in the same cycle keeps the flag set.
    always_comb begin
        overrun_d = overrun_q;
        framing_d = framing_q;
        if (rd_status) begin
            overrun_d = 1'b0;
            framing_d = 1'b0;
        end
        if (rx_push && fifo_full && !rd_data) begin
            overrun_d = 1'b1;
        end
        if (frame_err) begin
            framing_d = 1'b1;
        end
    end

    assign count5 = 5'(fifo_count);

    always_comb begin
        ioReadData = '0;
        if (rd_data && !fifo_empty) begin
            ioReadData = {24'b0, fifo_rdata};
        end else if (rd_status) begin
            ioReadData = rx_status_word(count5, fifo_full, framing_q, overrun_q, !fifo_empty);
        end
    end

    assign rxInterrupt = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_port.sv
// Bench for uart_rx_port: serial frames are driven bit by bit, expected bytes
// are queued when a frame is sent and checked against bus reads of the FIFO.
module tb_uart_rx_port;
    import soc_io_pkg::*;

    localparam int CPB   = 108;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        resetActiveLow;
    logic        uartReceive;
    logic        ioReadValid;
    logic [31:0] ioReadAddress;
    logic [31:0] ioReadData;
    logic        rxInterrupt;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [7:0]  exp_q[$];

    always #5 clock = ~clock;

    uart_rx_port #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock          (clock),
        .resetActiveLow (resetActiveLow),
        .uartReceive    (uartReceive),
        .ioReadValid    (ioReadValid),
        .ioReadAddress  (ioReadAddress),
        .ioReadData     (ioReadData),
        .rxInterrupt    (rxInterrupt)
    );

    // One-cycle bus read; data is captured mid-cycle, the access commits on the next edge.
    task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clock);
        ioReadValid   = 1'b1;
        ioReadAddress = addr;
        #1 data = ioReadData;
        @(posedge clock);
        #1;
        ioReadValid   = 1'b0;
        ioReadAddress = '0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit expect_push);
        if (expect_push) exp_q.push_back(b);
        @(negedge clock);
        uartReceive = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uartReceive = b[i];
            repeat (CPB) @(negedge clock);
        end
        uartReceive = stop_bit;
        repeat (CPB) @(negedge clock);
    endtask

    // Waits for the cycle in which a byte is pushed, then reads DATA in that same cycle.
    task automatic read_on_push(output logic [31:0] data, output bit timed_out);
        int n = 0;
        timed_out = 1'b0;
        data      = '0;
        @(negedge clock);
        while (dut.rx_push !== 1'b1 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 3000) begin
            timed_out = 1'b1;
        end else begin
            ioReadValid   = 1'b1;
            ioReadAddress = UART_RX_DATA_ADDR;
            #1 data = ioReadData;
            @(posedge clock);
            #1;
            ioReadValid   = 1'b0;
            ioReadAddress = '0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        resetActiveLow = 1'b0;
        uartReceive    = 1'b1;
        ioReadValid    = 1'b0;
        ioReadAddress  = '0;
        repeat (5) @(negedge clock);
        tests_run++;
        if (rxInterrupt !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_irq: got %b want 0", rxInterrupt);
        end
        resetActiveLow = 1'b1;
        repeat (3) @(negedge clock);
        tests_run++;
        if (dut.state_q !== RX_IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
        end
        do_read(UART_RX_STATUS_ADDR, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_status: got %h want 00000000", d);
        end
        do_read(UART_RX_DATA_ADDR, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_empty_data: got %h want 00000000", d);
        end
    endtask

    task automatic test_single_byte();
        logic [31:0] d;
        int cycles = 0;
        fork
            send_byte(8'hA5, 1'b1, 1'b1);
            begin
                @(negedge uartReceive);
                while (rxInterrupt !== 1'b1 && cycles < 2000) begin
                    @(posedge clock);
                    cycles++;
                    #1;
                end
            end
        join
        tests_run++;
        if (cycles < 1027 || cycles > 1029) begin
            tests_failed++;
            $display("FAIL single_latency: got %0d cycles want 1027..1029", cycles);
        end
        @(negedge clock);
        ioReadAddress = UART_RX_DATA_ADDR;
        #1;
        tests_run++;
        if (ioReadData !== 32'h0) begin
            tests_failed++;
            $display("FAIL idle_bus_data: got %h want 00000000", ioReadData);
        end
        ioReadAddress = '0;
        do_read(UART_TX_ADDR, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL other_addr: got %h want 00000000", d);
        end
        do_read(UART_RX_DATA_ADDR, d);
        tests_run++;
        if (exp_q.size() == 0 || d !== {24'b0, exp_q[0]}) begin
            tests_failed++;
            $display("FAIL single_data: got %h want 000000a5", d);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        do_read(UART_RX_STATUS_ADDR, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL single_status: got %h want 00000000", d);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        @(negedge clock);
        uartReceive = 1'b0;
        repeat (30) @(negedge clock);
        uartReceive = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        tests_run++;
        if (dut.state_q !== RX_IDLE || rxInterrupt !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_idle: got state %0d irq %b want IDLE 0", dut.state_q, rxInterrupt);
        end
        do_read(UART_RX_STATUS_ADDR, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL glitch_status: got %h want 00000000", d);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        logic [7:0]  e;
        for (int i = 1; i <= 9; i++) begin
            send_byte(8'(i), 1'b1, i <= DEPTH);
        end
        do_read(UART_RX_STATUS_ADDR, d);
        tests_run++;
        if (d !== 32'h0000008B) begin
            tests_failed++;
            $display("FAIL overrun_status: got %h want 0000008b", d);
        end
        for (int i = 0; i < DEPTH; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            do_read(UART_RX_DATA_ADDR, d);
            tests_run++;
            if (d !== {24'b0, e}) begin
                tests_failed++;
                $display("FAIL overrun_data[%0d]: got %h want %h", i, d, {24'b0, e});
            end
        end
        do_read(UART_RX_DATA_ADDR, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL overrun_lost_byte: got %h want 00000000", d);
        end
        do_read(UART_RX_STATUS_ADDR, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL overrun_cleared: got %h want 00000000", d);
        end
    endtask

    task automatic test_framing();
        logic [31:0] d;
        logic [7:0]  e;
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (500) @(negedge clock);
        uartReceive = 1'b1;
        repeat (20) @(negedge clock);
        tests_run++;
        if (dut.state_q !== RX_IDLE || rxInterrupt !== 1'b0) begin
            tests_failed++;
            $display("FAIL break_idle: got state %0d irq %b want IDLE 0", dut.state_q, rxInterrupt);
        end
        send_byte(8'h55, 1'b1, 1'b1);
        do_read(UART_RX_STATUS_ADDR, d);
        tests_run++;
        if (d !== 32'h00000015) begin
            tests_failed++;
            $display("FAIL framing_status: got %h want 00000015", d);
        end
        do_read(UART_RX_STATUS_ADDR, d);
        tests_run++;
        if (d !== 32'h00000011) begin
            tests_failed++;
            $display("FAIL framing_cleared: got %h want 00000011", d);
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        do_read(UART_RX_DATA_ADDR, d);
        tests_run++;
        if (d !== {24'b0, e}) begin
            tests_failed++;
            $display("FAIL framing_next_byte: got %h want %h", d, {24'b0, e});
        end
    endtask

    task automatic test_empty_push_pop();
        logic [31:0] d;
        logic [7:0]  e;
        bit          to;
        fork
            send_byte(8'h66, 1'b1, 1'b1);
            read_on_push(d, to);
        join
        tests_run++;
        if (to || d !== 32'h0) begin
            tests_failed++;
            $display("FAIL empty_pushpop_read: got %h timeout %b want 00000000", d, to);
        end
        do_read(UART_RX_STATUS_ADDR, d);
        tests_run++;
        if (d !== 32'h00000011) begin
            tests_failed++;
            $display("FAIL empty_pushpop_status: got %h want 00000011", d);
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        do_read(UART_RX_DATA_ADDR, d);
        tests_run++;
        if (d !== {24'b0, e}) begin
            tests_failed++;
            $display("FAIL empty_pushpop_data: got %h want %h", d, {24'b0, e});
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] d;
        logic [7:0]  e;
        bit          to;
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(8'h30 + 8'(i), 1'b1, 1'b1);
        end
        e = exp_q[0];
        fork
            send_byte(8'h30 + 8'(DEPTH), 1'b1, 1'b1);
            read_on_push(d, to);
        join
        tests_run++;
        if (to || d !== {24'b0, e}) begin
            tests_failed++;
            $display("FAIL full_pushpop_read: got %h timeout %b want %h", d, to, {24'b0, e});
        end
        void'(exp_q.pop_front());
        do_read(UART_RX_STATUS_ADDR, d);
        tests_run++;
        if (d !== 32'h00000089) begin
            tests_failed++;
            $display("FAIL full_pushpop_status: got %h want 00000089", d);
        end
        for (int i = 0; i < DEPTH; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            do_read(UART_RX_DATA_ADDR, d);
            tests_run++;
            if (d !== {24'b0, e}) begin
                tests_failed++;
                $display("FAIL full_pushpop_drain[%0d]: got %h want %h", i, d, {24'b0, e});
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        logic [7:0]  frame;
        logic [7:0]  e;
        frame = 8'hF0;
        @(negedge clock);
        uartReceive = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uartReceive = frame[i];
            if (i == 4) begin
                repeat (CPB / 2) @(negedge clock);
                resetActiveLow = 1'b0;
                repeat (3) @(negedge clock);
                resetActiveLow = 1'b1;
                repeat (CPB - CPB / 2 - 3) @(negedge clock);
            end else begin
                repeat (CPB) @(negedge clock);
            end
        end
        uartReceive = 1'b1;
        repeat (CPB + 10) @(negedge clock);
        tests_run++;
        if (dut.state_q !== RX_IDLE || rxInterrupt !== 1'b0) begin
            tests_failed++;
            $display("FAIL midframe_abandon: got state %0d irq %b want IDLE 0", dut.state_q, rxInterrupt);
        end
        send_byte(8'h12, 1'b1, 1'b1);
        do_read(UART_RX_STATUS_ADDR, d);
        tests_run++;
        if (d !== 32'h00000011) begin
            tests_failed++;
            $display("FAIL midframe_status: got %h want 00000011", d);
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        do_read(UART_RX_DATA_ADDR, d);
        tests_run++;
        if (d !== {24'b0, e}) begin
            tests_failed++;
            $display("FAIL midframe_data: got %h want %h", d, {24'b0, e});
        end
        do_read(UART_RX_STATUS_ADDR, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL midframe_empty: got %h want 00000000", d);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_overrun();
        test_framing();
        test_empty_push_pop();
        test_full_push_pop();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx_port.md
UART_RX_PORT -- requirements
Module: uart_rx_port

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 108: cpu clock cycles per serial bit, minimum 8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: receive FIFO entries, power of two, range 2..16.
REQ-003 SHALL have parameter DATA_ADDR, default 32'h40000008: receive-data register address.
REQ-004 SHALL have parameter STATUS_ADDR, default 32'h4000000C: receive-status register address.
REQ-005 SHALL have the ports below; reset is resetActiveLow, asynchronous, active-low; clock is clock.
- clock  in  1  cpu clock
- resetActiveLow  in  1  asynchronous active-low reset
- uartReceive  in  1  asynchronous serial line, idle high
- ioReadValid  in  1  bus read strobe, one cycle per access
- ioReadAddress  in  32  bus read address
- ioReadData  out  32  combinational read data
- rxInterrupt  out  1  high while FIFO non-empty

Function
REQ-006 SHALL synchronise uartReceive through two flops; the FSM uses only the synchronised value (2-cycle latency).
REQ-007 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-008 IDLE: a synchronised low moves the FSM to START and clears the bit counter.
REQ-009 START: at count CLKS_PER_BIT/2-1, low moves to DATA (counter cleared); high returns to IDLE as a glitch, with nothing pushed and no flag set.
REQ-010 DATA: every CLKS_PER_BIT cycles, sample one bit LSB-first into an 8-bit shifter; after bit 7, move to STOP.
REQ-011 STOP: after CLKS_PER_BIT cycles, sample the line.
- High: push the byte, then IDLE.
- Low: discard the byte, set framingError, then WAIT_HIGH.
REQ-012 WAIT_HIGH: hold until the synchronised line is high, then IDLE; line-break condition, no pushes.
REQ-013 Push into a full FIFO SHALL drop the new byte, leave FIFO contents intact, and set overrun.
REQ-014 Read of DATA_ADDR SHALL return {24'b0, head byte} and pop one entry in the same cycle.
- Empty FIFO: return 0, pointers unchanged.
REQ-015 Read of STATUS_ADDR SHALL return:
- bit0 notEmpty, bit1 overrun, bit2 framingError, bit3 full
- bits[8:4] count (0..FIFO_DEPTH)
- all other bits 0
REQ-016 A status read SHALL clear overrun and framingError on the following edge; an error event in the same cycle wins (flag stays set).
REQ-017 A simultaneous push and pop when full SHALL succeed without overrun; count unchanged.
REQ-018 A simultaneous push and pop when empty SHALL push only; the read returns 0.
REQ-019 Reads at other addresses SHALL return 0 with no side effects; ioReadData is 0 when ioReadValid is low.
REQ-020 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be maintained separately, width clog2(FIFO_DEPTH)+1.
REQ-021 The byte becomes visible (notEmpty=1) 2+CLKS_PER_BIT/2+9*CLKS_PER_BIT cycles (±1) after the line falls.

Reset
REQ-022 Reset SHALL force IDLE, clear counters, pointers, count, shifter, overrun and framingError, set the synchroniser flops high, and drive rxInterrupt=0.
REQ-023 Reset mid-frame SHALL abandon the frame; the first byte after reset is the next full valid frame.

Structure
REQ-024 A shared package soc_io_pkg SHALL hold the IO address constants (UART TX 0x40000000, TX status 0x40000004, DATA 0x40000008, STATUS 0x4000000C, MEPC 0x40000010) and the rx FSM state enum.
REQ-025 The FIFO SHALL be a sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count); the FSM and register decode live in uart_rx_port.

Verification
REQ-026 With CLKS_PER_BIT=108, send 0xA5 8N1 -> notEmpty rises 1028±1 cycles after the start edge; DATA read returns 0x000000A5; then status=0.
REQ-027 Pulse the line low for 30 cycles -> no push, no flags, FSM in IDLE.
REQ-028 Send 9 bytes 0x01..0x09 with FIFO_DEPTH=8, no reads -> status 0x0000008B (count 8, full, overrun, notEmpty); reads return 0x01..0x08; 0x09 is lost.
REQ-029 Send 0x3C with stop bit low, held low 500 cycles, then send 0x55 -> framingError set, 0x3C absent, 0x55 received; status read clears bit2.
REQ-030 Assert reset at data bit 4 of 0xF0, release, send 0x12 -> FIFO holds only 0x12.
REQ-031 FIFO full: pop on the same cycle as a push -> no overrun; count stays 8; order preserved.
